// File: rtl/tc_run_length_monitor.sv
// rtl/tc_run_length_monitor.sv - run-length monitor for a 1-bit line
// Converts the sampled bit line into (level, length, sat) records on a valid/ready port.
module tc_run_length_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_level,
  output logic [WIDTH-1:0] out_length,
  output logic             out_sat,
  output logic             overflow
);

  typedef enum logic {ARMED, RUN} state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic             level;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             emit;
  logic             slot_free;
  logic             at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARMED: state_next = RUN;
      RUN:   state_next = RUN;
    endcase
  end

  // A record exists only on a transition; the slot frees up in the same cycle it is accepted.
  always_comb begin
    emit      = (state == RUN) && (in != level);
    slot_free = !out_valid || out_ready;
    at_max    = (count == MAX_COUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      count <= '0;
      sat   <= 1'b0;
    end else if (state == ARMED || emit) begin
      level <= in;
      count <= ONE;
      sat   <= 1'b0;
    end else if (at_max) begin
      sat   <= 1'b1;
    end else begin
      count <= count + ONE;
    end
  end

  // A record arriving while the slot is still held is dropped and flagged, never overwrites.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_level  <= 1'b0;
      out_length <= '0;
      out_sat    <= 1'b0;
      overflow   <= 1'b0;
    end else if (emit && slot_free) begin
      out_valid  <= 1'b1;
      out_level  <= level;
      out_length <= count;
      out_sat    <= sat;
    end else if (emit) begin
      overflow   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tc_run_length_monitor.sv
// tb/tb_tc_run_length_monitor.sv - self-checking bench for tc_run_length_monitor
// Run-length model with unbounded lengths, checked every cycle plus literal record pins.
module tb_tc_run_length_monitor;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in;
  logic         out_ready;
  logic         out_valid;
  logic         out_level;
  logic [W-1:0] out_length;
  logic         out_sat;
  logic         overflow;

  tc_run_length_monitor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_level  (out_level),
    .out_length (out_length),
    .out_sat    (out_sat),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit lvl;
    int len;
    bit sat;
  } rec_t;

  // Model: true run lengths, clipped only when a record is formed.
  bit   started;
  bit   cur_level;
  int   cur_len;
  bit   m_valid;
  bit   m_level;
  int   m_length;
  bit   m_sat;
  bit   m_ovf;
  rec_t loaded[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      started = 0; cur_level = 0; cur_len = 0;
      m_valid = 0; m_level = 0; m_length = 0; m_sat = 0; m_ovf = 0;
    end else begin
      bit   have;
      rec_t r;
      have = 0;
      if (!started) begin
        started = 1; cur_level = in; cur_len = 1;
      end else if (in == cur_level) begin
        cur_len++;
      end else begin
        have  = 1;
        r.lvl = cur_level;
        r.len = (cur_len > MAX) ? MAX : cur_len;
        r.sat = (cur_len > MAX);
        cur_level = in; cur_len = 1;
      end
      if (have && (!m_valid || out_ready)) begin
        m_valid = 1; m_level = r.lvl; m_length = r.len; m_sat = r.sat;
        loaded.push_back(r);
      end else if (have) begin
        m_ovf = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_level", 32'(out_level), 32'(m_level));
    check("out_length", 32'(out_length), 32'(m_length));
    check("out_sat", 32'(out_sat), 32'(m_sat));
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic tick(input bit v, input bit r);
    in = v;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input bit v, input bit r, input int n);
    for (int i = 0; i < n; i++) tick(v, r);
  endtask

  task automatic restart();
    rst = 1'b0;
    tick(1'b0, 1'b1);
    rst = 1'b1;
    loaded.delete();
  endtask

  task automatic pin_rec(input string name, input int idx, input bit l, input int len, input bit s);
    check({name, "_count"}, 32'(loaded.size() > idx), 32'd1);
    if (loaded.size() > idx) begin
      check({name, "_level"}, 32'(loaded[idx].lvl), 32'(l));
      check({name, "_length"}, 32'(loaded[idx].len), 32'(len));
      check({name, "_sat"}, 32'(loaded[idx].sat), 32'(s));
    end
  endtask

  task automatic pin_out(input string name, input bit v, input bit l, input int len, input bit s, input bit o);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_level"}, 32'(out_level), 32'(l));
    check({name, "_length"}, 32'(out_length), 32'(len));
    check({name, "_sat"}, 32'(out_sat), 32'(s));
    check({name, "_overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    rst = 1'b1;
    in = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // reset hold with a toggling line
    for (int i = 0; i < 5; i++) tick(i[0], 1'b1);
    pin_out("reset_hold", 0, 0, 0, 0, 0);
    rst = 1'b1;
    loaded.delete();

    // basic runs: 0 x5, 1 x3, then 0
    ticks(1'b0, 1'b1, 5);
    ticks(1'b1, 1'b1, 1);
    pin_out("basic_rec0", 1, 0, 5, 0, 0);
    ticks(1'b1, 1'b1, 1);
    check("basic_pulse_1cyc", 32'(out_valid), 32'd0);
    ticks(1'b1, 1'b1, 1);
    ticks(1'b0, 1'b1, 1);
    pin_out("basic_rec1", 1, 1, 3, 0, 0);
    ticks(1'b0, 1'b1, 2);
    pin_rec("basic_m0", 0, 0, 5, 0);
    pin_rec("basic_m1", 1, 1, 3, 0);

    // saturation: 1 x20, 0 x2, then 1
    restart();
    ticks(1'b1, 1'b1, 20);
    ticks(1'b0, 1'b1, 1);
    pin_out("sat_rec0", 1, 1, 15, 1, 0);
    ticks(1'b0, 1'b1, 1);
    ticks(1'b1, 1'b1, 1);
    pin_out("sat_rec1", 1, 0, 2, 0, 0);
    ticks(1'b1, 1'b1, 2);
    pin_rec("sat_m0", 0, 1, 15, 1);
    pin_rec("sat_m1", 1, 0, 2, 0);

    // backpressure: 0 x3, 1, 0, 1 with ready low
    restart();
    ticks(1'b0, 1'b0, 3);
    ticks(1'b1, 1'b0, 1);
    ticks(1'b0, 1'b0, 1);
    ticks(1'b1, 1'b0, 1);
    pin_out("bp_held", 1, 0, 3, 0, 1);
    ticks(1'b1, 1'b1, 1);
    pin_out("bp_accepted", 0, 0, 3, 0, 1);
    ticks(1'b1, 1'b0, 3);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    check("bp_m_size", 32'(loaded.size()), 32'd1);

    // accept and emit in the same cycle
    restart();
    ticks(1'b0, 1'b0, 2);
    ticks(1'b1, 1'b0, 2);
    pin_out("coinc_held", 1, 0, 2, 0, 0);
    ticks(1'b0, 1'b1, 1);
    pin_out("coinc_replace", 1, 1, 2, 0, 0);
    ticks(1'b0, 1'b1, 1);
    check("coinc_drain", 32'(out_valid), 32'd0);
    pin_rec("coinc_m1", 1, 1, 2, 0);

    // mid-run reset, asserted mid-cycle while a record is held
    restart();
    ticks(1'b0, 1'b0, 2);
    ticks(1'b1, 1'b0, 4);
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    pin_out("midrst_async", 0, 0, 0, 0, 0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    rst = 1'b1;
    loaded.delete();
    ticks(1'b1, 1'b1, 2);
    ticks(1'b0, 1'b1, 1);
    pin_out("midrst_rec", 1, 1, 2, 0, 0);
    ticks(1'b0, 1'b1, 2);
    pin_rec("midrst_m0", 0, 1, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
